// File: rtl/issue_queue_param.sv
// Parameterised out-of-order issue queue.
// Multi-lane dispatch into the lowest free slots, tag wakeup with operand
// capture, and oldest-first selection of ready entries through an age matrix.
module issue_queue_param #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DISP_W  = 4,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned WAKE_W  = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned ROB_W   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [DISP_W-1:0]                disp_valid_i,
  output logic                             disp_ready_o,
  input  logic [DISP_W-1:0][TAG_W-1:0]     disp_src1_tag_i,
  input  logic [DISP_W-1:0][TAG_W-1:0]     disp_src2_tag_i,
  input  logic [DISP_W-1:0]                disp_src1_rdy_i,
  input  logic [DISP_W-1:0]                disp_src2_rdy_i,
  input  logic [DISP_W-1:0][DATA_W-1:0]    disp_op1_i,
  input  logic [DISP_W-1:0][DATA_W-1:0]    disp_op2_i,
  input  logic [DISP_W-1:0][TAG_W-1:0]     disp_dest_i,
  input  logic [DISP_W-1:0][ROB_W-1:0]     disp_rob_idx_i,
  input  logic [WAKE_W-1:0]                wake_valid_i,
  input  logic [WAKE_W-1:0][TAG_W-1:0]     wake_tag_i,
  input  logic [WAKE_W-1:0][DATA_W-1:0]    wake_data_i,
  output logic [ISSUE_W-1:0]               issue_valid_o,
  input  logic [ISSUE_W-1:0]               issue_ready_i,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_op1_o,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_op2_o,
  output logic [ISSUE_W-1:0][TAG_W-1:0]    issue_dest_o,
  output logic [ISSUE_W-1:0][ROB_W-1:0]    issue_rob_idx_o,
  output logic [$clog2(DEPTH):0]           free_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  // Entry state
  logic [DEPTH-1:0]                valid_q;
  logic [DEPTH-1:0]                s1_rdy_q;
  logic [DEPTH-1:0]                s2_rdy_q;
  logic [DEPTH-1:0][TAG_W-1:0]     s1_tag_q;
  logic [DEPTH-1:0][TAG_W-1:0]     s2_tag_q;
  logic [DEPTH-1:0][DATA_W-1:0]    op1_q;
  logic [DEPTH-1:0][DATA_W-1:0]    op2_q;
  logic [DEPTH-1:0][TAG_W-1:0]     dest_q;
  logic [DEPTH-1:0][ROB_W-1:0]     rob_q;
  // age_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0]     age_q;
  logic [DEPTH-1:0][DEPTH-1:0]     age_d;
  logic [CNT_W-1:0]                free_q;

  // Wakeup results for resident entries
  logic [DEPTH-1:0]                s1_wk;
  logic [DEPTH-1:0]                s2_wk;
  logic [DEPTH-1:0][DATA_W-1:0]    s1_wd;
  logic [DEPTH-1:0][DATA_W-1:0]    s2_wd;
  // Wakeup results for dispatching lanes
  logic [DISP_W-1:0]               d1_wk;
  logic [DISP_W-1:0]               d2_wk;
  logic [DISP_W-1:0][DATA_W-1:0]   d1_wd;
  logic [DISP_W-1:0][DATA_W-1:0]   d2_wd;

  // Allocation
  logic                            disp_fire;
  logic [DEPTH-1:0]                taken;
  logic [DISP_W-1:0]               lane_en;
  logic [DISP_W-1:0][IDX_W-1:0]    lane_idx;
  logic [CNT_W-1:0]                disp_cnt;

  // Selection
  logic [DEPTH-1:0]                elig;
  logic [DEPTH-1:0][CNT_W-1:0]     rank;
  logic [ISSUE_W-1:0]              sel_v;
  logic [ISSUE_W-1:0][IDX_W-1:0]   sel_idx;
  logic [DEPTH-1:0]                rel;
  logic [CNT_W-1:0]                issue_cnt;

  assign free_cnt_o   = free_q;
  assign disp_ready_o = (free_q >= CNT_W'(DISP_W));
  assign disp_fire    = disp_ready_o && !flush_i;
  assign elig         = valid_q & s1_rdy_q & s2_rdy_q;

  // Match broadcast tags against resident sources; lowest port wins
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      s1_wk[i] = 1'b0;
      s2_wk[i] = 1'b0;
      s1_wd[i] = '0;
      s2_wd[i] = '0;
      for (int unsigned w = 0; w < WAKE_W; w++) begin
        if (!s1_wk[i] && wake_valid_i[w] && (wake_tag_i[w] == s1_tag_q[i])) begin
          s1_wk[i] = 1'b1;
          s1_wd[i] = wake_data_i[w];
        end
        if (!s2_wk[i] && wake_valid_i[w] && (wake_tag_i[w] == s2_tag_q[i])) begin
          s2_wk[i] = 1'b1;
          s2_wd[i] = wake_data_i[w];
        end
      end
    end
  end

  // Match broadcast tags against dispatching sources; lowest port wins
  always_comb begin
    for (int unsigned l = 0; l < DISP_W; l++) begin
      d1_wk[l] = 1'b0;
      d2_wk[l] = 1'b0;
      d1_wd[l] = '0;
      d2_wd[l] = '0;
      for (int unsigned w = 0; w < WAKE_W; w++) begin
        if (!d1_wk[l] && wake_valid_i[w] && (wake_tag_i[w] == disp_src1_tag_i[l])) begin
          d1_wk[l] = 1'b1;
          d1_wd[l] = wake_data_i[w];
        end
        if (!d2_wk[l] && wake_valid_i[w] && (wake_tag_i[w] == disp_src2_tag_i[l])) begin
          d2_wk[l] = 1'b1;
          d2_wd[l] = wake_data_i[w];
        end
      end
    end
  end

  // Give each valid lane the lowest still-free slot, in lane order
  always_comb begin
    taken    = '0;
    lane_en  = '0;
    lane_idx = '0;
    disp_cnt = '0;
    for (int unsigned l = 0; l < DISP_W; l++) begin
      if (disp_fire && disp_valid_i[l]) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!lane_en[l] && !valid_q[i] && !taken[i]) begin
            lane_en[l]  = 1'b1;
            taken[i]    = 1'b1;
            lane_idx[l] = IDX_W'(i);
            disp_cnt    = disp_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Next age matrix. Because lower lanes land in lower free slots, slot
  // order among the new entries equals lane order, so j > i suffices.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (taken[i])
          age_d[i][j] = taken[j] && (j > i);
        else if (taken[j])
          age_d[i][j] = valid_q[i];
        else
          age_d[i][j] = age_q[i][j];
      end
    end
  end

  // Rank of each entry = number of older eligible entries
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < DEPTH; j++)
        rank[i] = rank[i] + CNT_W'(elig[j] & age_q[j][i]);
    end
  end

  // Port p carries the eligible entry of rank p; accepted ports release it
  always_comb begin
    sel_v           = '0;
    sel_idx         = '0;
    rel             = '0;
    issue_cnt       = '0;
    issue_valid_o   = '0;
    issue_op1_o     = '0;
    issue_op2_o     = '0;
    issue_dest_o    = '0;
    issue_rob_idx_o = '0;
    for (int unsigned p = 0; p < ISSUE_W; p++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (elig[i] && (rank[i] == CNT_W'(p))) begin
          sel_v[p]   = 1'b1;
          sel_idx[p] = IDX_W'(i);
        end
      end
      if (sel_v[p]) begin
        issue_valid_o[p]   = 1'b1;
        issue_op1_o[p]     = op1_q[sel_idx[p]];
        issue_op2_o[p]     = op2_q[sel_idx[p]];
        issue_dest_o[p]    = dest_q[sel_idx[p]];
        issue_rob_idx_o[p] = rob_q[sel_idx[p]];
        if (issue_ready_i[p]) begin
          rel[sel_idx[p]] = 1'b1;
          issue_cnt       = issue_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Control state: valid/ready bits, age matrix and free count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      age_q    <= '0;
      free_q   <= CNT_W'(DEPTH);
    end else if (flush_i) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      age_q    <= '0;
      free_q   <= CNT_W'(DEPTH);
    end else begin
      valid_q <= (valid_q & ~rel) | taken;
      age_q   <= age_d;
      free_q  <= free_q + issue_cnt - disp_cnt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !s1_rdy_q[i] && s1_wk[i]) s1_rdy_q[i] <= 1'b1;
        if (valid_q[i] && !s2_rdy_q[i] && s2_wk[i]) s2_rdy_q[i] <= 1'b1;
      end
      for (int unsigned l = 0; l < DISP_W; l++) begin
        if (lane_en[l]) begin
          s1_rdy_q[lane_idx[l]] <= disp_src1_rdy_i[l] | d1_wk[l];
          s2_rdy_q[lane_idx[l]] <= disp_src2_rdy_i[l] | d2_wk[l];
        end
      end
    end
  end

  // Payload: operands, tags and ROB index; qualified by the valid bits
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !s1_rdy_q[i] && s1_wk[i]) op1_q[i] <= s1_wd[i];
      if (valid_q[i] && !s2_rdy_q[i] && s2_wk[i]) op2_q[i] <= s2_wd[i];
    end
    for (int unsigned l = 0; l < DISP_W; l++) begin
      if (lane_en[l]) begin
        s1_tag_q[lane_idx[l]] <= disp_src1_tag_i[l];
        s2_tag_q[lane_idx[l]] <= disp_src2_tag_i[l];
        op1_q[lane_idx[l]]    <= (!disp_src1_rdy_i[l] && d1_wk[l]) ? d1_wd[l] : disp_op1_i[l];
        op2_q[lane_idx[l]]    <= (!disp_src2_rdy_i[l] && d2_wk[l]) ? d2_wd[l] : disp_op2_i[l];
        dest_q[lane_idx[l]]   <= disp_dest_i[l];
        rob_q[lane_idx[l]]    <= disp_rob_idx_i[l];
      end
    end
  end

endmodule
